uart_wb_master: RTL
===================

UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 The block SHALL expose parameter TIMEOUT_CYC, default 16, meaning the maximum number of cycles a Wishbone cycle waits for ack before it aborts.
REQ-002 The block SHALL expose parameter SEL_VAL, default 4'b0001, meaning the constant byte-select driven during every bus cycle.
REQ-003 wb_clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 wb_rst_i  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a clock edge.
REQ-007 cmd_we  in  1  1 = register write, 0 = register read.
REQ-008 cmd_adr  in  3  UART register address.
REQ-009 cmd_dat  in  8  write data.
REQ-010 rsp_valid  out  1  response held.
REQ-011 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high on a clock edge.
REQ-012 rsp_dat  out  8  read data; 0 for writes and for timeouts.
REQ-013 rsp_err  out  1  ack timeout occurred.
REQ-014 wb_adr_o/wb_dat_o/wb_sel_o/wb_stb_o/wb_cyc_o/wb_we_o  out  3/8/4/1/1/1  Wishbone master outputs to the UART.
REQ-015 wb_dat_i  in  8  UART read data.
REQ-016 wb_ack_i  in  1  UART acknowledge.
REQ-017 int_i  in  1  UART interrupt.
REQ-018 irq_o  out  1  int_i after a two-flop synchronizer.

Function
REQ-019 FSM states SHALL be IDLE, BUS and RESP; reset state is IDLE.
REQ-020 IDLE: cmd_ready=1; on acceptance, latch we/adr/dat, drive cyc=stb=1, sel=SEL_VAL, and go to BUS on the next edge (cyc asserts the cycle after acceptance).
REQ-021 BUS: hold all Wishbone outputs stable; cmd_ready=0; the timeout counter increments each cycle with ack low.
REQ-022 On wb_ack_i=1 in BUS, capture wb_dat_i if a read (0 if a write), set rsp_err=0, deassert cyc/stb on the next edge, and go to RESP.
REQ-023 If the counter reaches TIMEOUT_CYC without ack, deassert cyc/stb, set rsp_err=1, set rsp_dat=0, and go to RESP.
REQ-024 Ack arriving in the same cycle the counter reaches TIMEOUT_CYC SHALL count as success.
REQ-025 An ack seen outside BUS SHALL be ignored.
REQ-026 RESP: rsp_valid=1 with rsp_dat/rsp_err stable until rsp_ready; on handshake return to IDLE.
REQ-027 The minimum command-to-rsp_valid latency SHALL be 3 cycles (accept, ack in the first BUS cycle, RESP).
REQ-028 The block SHALL support at most one outstanding command; a new command is not accepted in the same cycle as the rsp handshake.
REQ-029 The counter width SHALL be $clog2(TIMEOUT_CYC+1); it clears on entry to BUS and never wraps.

Reset
REQ-030 Asserting wb_rst_i SHALL immediately force IDLE, cyc=stb=we=0, adr=0, dat_o=0, sel=0, cmd_ready=0 (1 from the first edge after release), rsp_valid=0, rsp_dat=0, rsp_err=0, irq_o=0, and synchronizer flops=0.
REQ-031 Reset asserted mid-BUS SHALL abort the cycle with no response generated.

Structure
REQ-032 Package uart_wb_pkg SHALL hold the FSM state enum, UART register address constants (RBR_THR=0, IER=1, IIR_FCR=2, LCR=3, MCR=4, LSR=5, MSR=6, SCR=7), and a default timeout constant.
REQ-033 The two-flop synchronizer SHALL be a sub-module named uart_sync2.

Verification
REQ-034 Write LCR=8'h83, ack after 2 cycles -> wb_adr_o=3, wb_dat_o=8'h83, wb_we_o=1 for 3 cycles; rsp_err=0, rsp_dat=0.
REQ-035 Read LSR with wb_dat_i=8'h60 and immediate ack -> rsp_valid on the 3rd cycle after acceptance, rsp_dat=8'h60.
REQ-036 No ack, TIMEOUT_CYC=16 -> cyc high for exactly 16 cycles, then rsp_err=1, rsp_dat=0.
REQ-037 rsp_ready held low for 10 cycles -> rsp_valid/rsp_dat stable and cmd_ready=0 throughout.
REQ-038 Reset pulse in BUS cycle 2 -> cyc/stb low asynchronously, no rsp_valid, next command completes normally.
REQ-039 int_i rising edge -> irq_o high exactly 2 edges later.

Source files
------------

// File: rtl/uart_wb_pkg.sv
// uart_wb_pkg
//   Shared definitions for the UART Wishbone command bridge:
//   - state_t      : bridge FSM states
//   - ADR_*        : UART (16550-style) register addresses
//   - DEFAULT_TIMEOUT_CYC : default ack timeout, in wb_clk_i cycles
package uart_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] ADR_RBR_THR = 3'd0;
    localparam logic [2:0] ADR_IER     = 3'd1;
    localparam logic [2:0] ADR_IIR_FCR = 3'd2;
    localparam logic [2:0] ADR_LCR     = 3'd3;
    localparam logic [2:0] ADR_MCR     = 3'd4;
    localparam logic [2:0] ADR_LSR     = 3'd5;
    localparam logic [2:0] ADR_MSR     = 3'd6;
    localparam logic [2:0] ADR_SCR     = 3'd7;

    localparam int DEFAULT_TIMEOUT_CYC = 16;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2
//   Two-flop synchronizer for a single asynchronous level.
//   Ports:
//     clk   in  destination clock
//     rst_n in  asynchronous active-low reset, clears both flops
//     d     in  asynchronous input
//     q     out synchronized output (two edges of latency)
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_wb_master.sv
// uart_wb_master
//   Turns single register commands (read/write of a UART register) into
//   Wishbone classic cycles, with an ack timeout, and returns one response
//   per command. Also synchronizes the UART interrupt into wb_clk_i.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a command (cmd_ready=1)
//   BUS   | Wishbone cycle in flight, waiting for ack or timeout
//   RESP  | response held on rsp_* until rsp_ready
//
//   Ports:
//     wb_clk_i, wb_rst_i (async, active-low)
//     cmd_valid/cmd_ready/cmd_we/cmd_adr/cmd_dat : command channel
//     rsp_valid/rsp_ready/rsp_dat/rsp_err        : response channel
//     wb_adr_o/wb_dat_o/wb_sel_o/wb_stb_o/wb_cyc_o/wb_we_o,
//     wb_dat_i/wb_ack_i                          : Wishbone master
//     int_i -> irq_o                             : synchronized interrupt
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int         TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter logic [3:0] SEL_VAL     = 4'b0001
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,

    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic [2:0] cmd_adr,
    input  logic [7:0] cmd_dat,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_dat,
    output logic       rsp_err,

    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    output logic [3:0] wb_sel_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    output logic       wb_we_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i,

    input  logic       int_i,
    output logic       irq_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    // Last BUS cycle allowed without ack: the counter would reach
    // TIMEOUT_CYC at the end of it.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    logic cmd_accept;
    logic bus_ack;
    logic bus_timeout;

    assign cmd_accept  = cmd_valid && cmd_ready;
    // Ack only matters while a cycle is in flight; stray acks are ignored.
    assign bus_ack     = (state_q == ST_BUS) && wb_ack_i;
    // Ack has priority: an ack in the final allowed cycle is a success.
    assign bus_timeout = (state_q == ST_BUS) && !wb_ack_i && (cnt_q == CNT_LAST);
    assign rsp_valid   = (state_q == ST_RESP);

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_accept)               state_d = ST_BUS;
            ST_BUS:  if (bus_ack || bus_timeout)   state_d = ST_RESP;
            ST_RESP: if (rsp_ready)                state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cmd_ready <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            cnt_q     <= '0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            // Registered so it stays low during reset and during the
            // response handshake cycle (one command outstanding at most).
            cmd_ready <= (state_d == ST_IDLE);

            if (state_q == ST_IDLE && cmd_accept) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_we_o  <= cmd_we;
                wb_adr_o <= cmd_adr;
                wb_dat_o <= cmd_dat;
                wb_sel_o <= SEL_VAL;
                cnt_q    <= '0;
            end else if (state_q == ST_BUS) begin
                if (wb_ack_i) begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_we_o  <= 1'b0;
                    rsp_dat  <= wb_we_o ? 8'h00 : wb_dat_i;
                    rsp_err  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus_timeout) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        rsp_dat  <= 8'h00;
                        rsp_err  <= 1'b1;
                    end
                end
            end
        end
    end

    uart_sync2 u_irq_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .d     (int_i),
        .q     (irq_o)
    );

endmodule
